// File: rtl/grf_wb_arbiter.sv
// Arbitrates the GRF write port between W-stage writeback and the mult/div result path.
// Define GRF_ARB_STARVE_EN to build the starvation counter, FORCE/HOLD states and hold buffer.
module grf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        stall_wb,
  output logic        RegWrite,
  output logic [4:0]  RegAddr,
  output logic [31:0] RegData,
  output logic [31:0] pc
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

`ifdef GRF_ARB_STARVE_EN
  typedef enum logic [1:0] {StIdle, StWait, StForce, StHold} state_e;
  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        hold_valid_q, hold_load;
  logic [4:0]  hold_addr_q;
  logic [31:0] hold_data_q, hold_pc_q;
  logic        force_sel;
`else
  typedef enum logic {StIdle, StWait} state_e;
`endif

  state_e      state_q, state_d;
  logic        wb_req, md_xfer;
  logic        we_d;
  logic [4:0]  addr_d;
  logic [31:0] data_d, pc_d;

  assign wb_req  = wb_we && (wb_addr != 5'd0);
  assign md_xfer = md_valid && md_ready;

`ifdef GRF_ARB_STARVE_EN
  assign force_sel = (state_q == StForce) && md_valid;
  assign stall_wb  = hold_valid_q;
`else
  assign stall_wb  = 1'b0;
`endif

  // Ready is withheld only from a request that actually loses to the W stage.
  always_comb begin
    md_ready = 1'b0;
    if (!reset) begin
`ifdef GRF_ARB_STARVE_EN
      if (hold_valid_q) md_ready = 1'b0;
      else if (force_sel) md_ready = 1'b1;
      else
`endif
      md_ready = !(md_valid && wb_req);
    end
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    pc_d   = '0;
`ifdef GRF_ARB_STARVE_EN
    hold_load = 1'b0;
    if (hold_valid_q) begin
      we_d   = 1'b1;
      addr_d = hold_addr_q;
      data_d = hold_data_q;
      pc_d   = hold_pc_q;
    end else if (force_sel) begin
      hold_load = wb_req;
      if (md_addr != 5'd0) begin
        we_d   = 1'b1;
        addr_d = md_addr;
        data_d = md_data;
        pc_d   = md_pc;
      end
    end else
`endif
    if (wb_req) begin
      we_d   = 1'b1;
      addr_d = wb_addr;
      data_d = wb_data;
      pc_d   = wb_pc;
    end else if (md_valid && (md_addr != 5'd0)) begin
      we_d   = 1'b1;
      addr_d = md_addr;
      data_d = md_data;
      pc_d   = md_pc;
    end
  end

`ifdef GRF_ARB_STARVE_EN
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle, StWait: begin
        if (!md_valid || md_xfer) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if ((wait_cnt_q + 4'd1) >= Limit) begin
          state_d    = StForce;
          wait_cnt_d = '0;
        end else begin
          state_d    = StWait;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StForce: state_d = hold_load ? StHold : StIdle;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end
`else
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StWait: state_d = (md_valid && !md_xfer) ? StWait : StIdle;
      default:        state_d = StIdle;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      RegWrite <= 1'b0;
      RegAddr  <= '0;
      RegData  <= '0;
      pc       <= '0;
    end else begin
      state_q  <= state_d;
      RegWrite <= we_d;
      RegAddr  <= addr_d;
      RegData  <= data_d;
      pc       <= pc_d;
    end
  end

`ifdef GRF_ARB_STARVE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_pc_q    <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      hold_valid_q <= hold_load;
      if (hold_load) begin
        hold_addr_q <= wb_addr;
        hold_data_q <= wb_data;
        hold_pc_q   <= wb_pc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter; expected GRF writes are queued when driven, checked next cycle.
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, wb_pc;
  logic        md_valid, md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data, md_pc;
  logic        stall_wb, RegWrite;
  logic [4:0]  RegAddr;
  logic [31:0] RegData, pc;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  grf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_pc    (wb_pc),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .md_pc    (md_pc),
    .stall_wb (stall_wb),
    .RegWrite (RegWrite),
    .RegAddr  (RegAddr),
    .RegData  (RegData),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ex(input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] p, input logic st);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.pc = p; e.stall = st;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs, check combinational ready, then check registered outputs after the edge.
  task automatic step(input string tag, input logic rst,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] wp,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic [31:0] mp,
                      input logic erdy, input exp_t e);
    exp_t got;
    reset = rst; wb_we = we; wb_addr = wa; wb_data = wd; wb_pc = wp;
    md_valid = mv; md_addr = ma; md_data = md; md_pc = mp;
    #1;
    check({tag, ".md_ready"}, 32'(md_ready), 32'(erdy));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ".RegWrite"}, 32'(RegWrite), 32'(got.we));
    check({tag, ".RegAddr"},  32'(RegAddr),  32'(got.addr));
    check({tag, ".RegData"},  RegData,       got.data);
    check({tag, ".pc"},       pc,            got.pc);
    check({tag, ".stall_wb"}, 32'(stall_wb), 32'(got.stall));
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset with an md request present: ready must still be low, outputs cleared.
    step("reset", 1'b1, 1'b1, 5'd4, 32'h9, 32'h9, 1'b1, 5'd3, 32'h7, 32'h7, 1'b0, ex(0, 0, 0, 0, 0));

    step("wb_only", 1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'h0, 32'h0,
         1'b1, ex(1, 5'd5, 32'h1234, 32'h3000, 0));
    step("md_only", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8, 32'hAA, 32'h4000,
         1'b1, ex(1, 5'd8, 32'hAA, 32'h4000, 0));
    step("wb_zero", 1'b0, 1'b1, 5'd0, 32'h55, 32'h5000, 1'b1, 5'd9, 32'hBB, 32'h4004,
         1'b1, ex(1, 5'd9, 32'hBB, 32'h4004, 0));
    step("md_zero", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hEE, 32'h4008,
         1'b1, ex(0, 0, 0, 0, 0));
    step("idle", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
         1'b1, ex(0, 0, 0, 0, 0));

`ifdef GRF_ARB_STARVE_EN
    for (int k = 2; k <= 5; k++) begin
      step("starve_wb", 1'b0, 1'b1, 5'(k), 32'(32'h100 + k), 32'(32'h1000 + 4 * k),
           1'b1, 5'd10, 32'hCC, 32'h6000,
           1'b0, ex(1, 5'(k), 32'(32'h100 + k), 32'(32'h1000 + 4 * k), 0));
    end
    step("starve_force", 1'b0, 1'b1, 5'd6, 32'h106, 32'h1018, 1'b1, 5'd10, 32'hCC, 32'h6000,
         1'b1, ex(1, 5'd10, 32'hCC, 32'h6000, 1));
    step("starve_hold", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
         1'b0, ex(1, 5'd6, 32'h106, 32'h1018, 0));
    step("starve_next", 1'b0, 1'b1, 5'd7, 32'h107, 32'h101C, 1'b0, 5'd0, 32'h0, 32'h0,
         1'b1, ex(1, 5'd7, 32'h107, 32'h101C, 0));

    for (int k = 2; k <= 5; k++) begin
      step("rst_wb", 1'b0, 1'b1, 5'(k), 32'(32'h200 + k), 32'(32'h2000 + 4 * k),
           1'b1, 5'd11, 32'hDD, 32'h7000,
           1'b0, ex(1, 5'(k), 32'(32'h200 + k), 32'(32'h2000 + 4 * k), 0));
    end
    step("rst_force", 1'b0, 1'b1, 5'd6, 32'h206, 32'h2018, 1'b1, 5'd11, 32'hDD, 32'h7000,
         1'b1, ex(1, 5'd11, 32'hDD, 32'h7000, 1));
    step("rst_in_hold", 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
         1'b0, ex(0, 0, 0, 0, 0));
    step("post_rst", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
         1'b1, ex(0, 0, 0, 0, 0));
`else
    for (int k = 2; k <= 7; k++) begin
      step("strict_wb", 1'b0, 1'b1, 5'(k), 32'(32'h100 + k), 32'(32'h1000 + 4 * k),
           1'b1, 5'd10, 32'hCC, 32'h6000,
           1'b0, ex(1, 5'(k), 32'(32'h100 + k), 32'(32'h1000 + 4 * k), 0));
    end
    step("strict_md", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd10, 32'hCC, 32'h6000,
         1'b1, ex(1, 5'd10, 32'hCC, 32'h6000, 0));
    step("strict_wb2", 1'b0, 1'b1, 5'd12, 32'h300, 32'h3100, 1'b1, 5'd13, 32'hDD, 32'h7000,
         1'b0, ex(1, 5'd12, 32'h300, 32'h3100, 0));
    step("rst_in_wait", 1'b1, 1'b1, 5'd14, 32'h301, 32'h3104, 1'b1, 5'd13, 32'hDD, 32'h7000,
         1'b0, ex(0, 0, 0, 0, 0));
    step("post_rst", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
         1'b1, ex(0, 0, 0, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Shares the single GRF write port (RegWrite/RegAddr/RegData/pc) between the pipeline W-stage writeback and the multi-cycle mult/div unit's result path. The W stage has priority; the mult/div unit uses a valid/ready handshake. A starvation counter and one-entry hold buffer guarantee the mult/div result a slot. Outputs are registered and drive the GRF write inputs directly.

## Interface
- STARVE_LIMIT, 4: consecutive denied cycles before the mult/div request is forced through (1..15).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the rising edge where it is 1.
- wb_we  in  1  W-stage write request.
- wb_addr  in  5  W-stage destination register.
- wb_data  in  32  W-stage write data.
- wb_pc  in  32  W-stage instruction PC, for trace.
- md_valid  in  1  mult/div result request; held stable until accepted.
- md_ready  out  1  combinational accept; a transfer occurs when md_valid && md_ready.
- md_addr  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- md_pc  in  32  mult/div instruction PC.
- stall_wb  out  1  registered; while 1, the pipeline freezes W and presents wb_we=0.
- RegWrite  out  1  registered GRF write enable.
- RegAddr  out  5  registered GRF write address.
- RegData  out  32  registered GRF write data.
- pc  out  32  registered PC forwarded to the GRF trace.

## Operation
- Source selection each cycle, in priority order:
  - HOLD: hold_valid=1. Write the hold buffer; md_ready=0; wb_we ignored.
  - FORCE: md_valid=1. md wins, md_ready=1; a concurrent wb request with wb_addr!=0 is captured into the hold buffer.
  - NORMAL: wb_we && wb_addr!=0 wins; md_ready=0.
  - Otherwise md_ready=1.
- Writes to $0 are dropped from either source and produce RegWrite=0:
  - A wb request with wb_addr=0 does not block md.
  - An md request with md_addr=0 is accepted (md_ready=1 unless HOLD) and discarded.
- FSM states:
  - IDLE: no md waiting.
  - WAIT: md_valid && !md_ready; wait_cnt increments each such cycle.
  - FORCE: entered on the cycle after wait_cnt reaches STARVE_LIMIT.
  - HOLD: entered after FORCE if the hold buffer was loaded; otherwise the FSM returns to IDLE. HOLD always returns to IDLE.
  - IDLE/WAIT to IDLE on any md transfer or on md_valid falling; wait_cnt cleared.
- stall_wb = hold_valid (registered), so it is 1 exactly during the HOLD cycle.
- The W-stage writeback that was held is not lost: it is written one cycle after the md write, in order.

## Timing
- Request to GRF port: 1 cycle. The source chosen in cycle N appears on RegWrite/RegAddr/RegData/pc in cycle N+1. The GRF commits the write at the end of cycle N+1.
- Worst-case md latency from md_valid rising to acceptance: STARVE_LIMIT+1 cycles.
- A held wb write is delayed by exactly 1 cycle relative to an unstalled write.
- Reset values:
  - RegWrite=0, RegAddr=0, RegData=0, pc=0.
  - md_ready=0 during reset.
  - stall_wb=0, hold_valid=0, wait_cnt=0, state IDLE.
- Reset mid-operation: pending hold and wait state are discarded. The output register is cleared, so any in-flight write is suppressed.
- md_valid dropping while in FORCE: treat the cycle as NORMAL, with no hold load.

## Configuration
- GRF_ARB_STARVE_EN defined: FORCE/HOLD states, wait_cnt, hold buffer and stall_wb are implemented as above.
- Undefined: strict W-stage priority only. stall_wb is tied to 0, and md can wait indefinitely. Only the IDLE/WAIT states exist, and the counter is not built.

## Test plan
- wb_we=1, addr=5, data=0x1234, pc=0x3000; md_valid=0 -> next cycle RegWrite=1, RegAddr=5, RegData=0x1234, pc=0x3000; md_ready=1 in the request cycle.
- md_valid=1 (addr=8, data=0xAA), wb_we=0 -> md_ready=1 same cycle; next cycle RegAddr=8, RegData=0xAA.
- wb_we=1, addr=0 together with md_valid=1, addr=9 -> md accepted; next cycle RegAddr=9; no $0 write.
- STARVE_LIMIT=4, md_valid=1 (addr=10), wb_we=1 every cycle (addr=2..7):
  - md_ready=0 for 4 cycles, then 1 in cycle 5.
  - Writes appear as 2,3,4,5,10,6.
  - stall_wb=1 for exactly one cycle; the held wb write (addr=6) is emitted then.
  - The pipeline's next write (addr=7) follows without loss.
- Assert reset while in HOLD -> next cycle all outputs 0, state IDLE, held write not performed.
- GRF_ARB_STARVE_EN undefined, same stimulus as the starvation scenario -> md_ready stays 0 while wb_we=1, and stall_wb stays 0.
